fabosc_clken_gen: RTL

FABOSC_CLKEN_GEN -- requirements
Module: fabosc_clken_gen

---
 rtl/fabosc_pkg.sv | 17 +
 rtl/fabosc_clken_ch.sv | 70 +++++++
 rtl/fabosc_clken_gen.sv | 90 +++++++++
 3 files changed

// File: rtl/fabosc_pkg.sv
// Shared types and constants for the fabric-oscillator clock-enable generator.
package fabosc_pkg;

  localparam int TICK_CNT_W         = 32;
  localparam int FABOSC_DEFAULT_DIV = 50;

  typedef enum logic [0:0] {
    UPD_IDLE = 1'b0,
    UPD_PEND = 1'b1
  } upd_state_t;

  // Width of a channel index; a single channel still needs one select bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fabosc_clken_ch.sv
// One clock-enable channel: down-counter, divisor register and registered tick.
// Optional per-channel tick counter under FABOSC_TICK_CNT_EN.
module fabosc_clken_ch
  import fabosc_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = FABOSC_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             wrap,
  output logic             tick
`ifdef FABOSC_TICK_CNT_EN
  ,
  output logic [TICK_CNT_W-1:0] tick_cnt
`endif
);

  localparam int RST_CNT = (DEFAULT_DIV > 1) ? DEFAULT_DIV - 1 : 0;

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] eff_m1;
  logic [DIV_W-1:0] load_m1;
  logic             tick_d;

  // Divisors 0 and 1 both mean "every enabled cycle", so reload value is max(div,1)-1.
  assign eff_m1  = (div_q == '0)    ? '0 : div_q - 1'b1;
  assign load_m1 = (load_div == '0) ? '0 : load_div - 1'b1;
  assign wrap    = en && (cnt_q == '0);
  assign tick_d  = wrap && !sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= DIV_W'(DEFAULT_DIV);
      cnt_q <= DIV_W'(RST_CNT);
      tick  <= 1'b0;
    end else begin
      tick <= tick_d;
      if (load) begin
        div_q <= load_div;
        cnt_q <= load_m1;
      end else if (sync || !en || (cnt_q == '0)) begin
        cnt_q <= eff_m1;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

`ifdef FABOSC_TICK_CNT_EN
  logic [TICK_CNT_W-1:0] tick_cnt_q;

  // Counts on the same edge the tick asserts so TICK_CNT and TICK stay in step.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else if (tick_d) begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  assign tick_cnt = tick_cnt_q;
`endif

endmodule

// File: rtl/fabosc_clken_gen.sv
// Multi-channel clock-enable generator with a one-deep divisor update queue.
// Define FABOSC_TICK_CNT_EN to add per-channel 32-bit tick counters on tick_cnt.
module fabosc_clken_gen
  import fabosc_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = FABOSC_DEFAULT_DIV,
  localparam int CH_W       = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  input  logic              div_valid,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [DIV_W-1:0]  div_value,
  output logic              div_ready,
  output logic [NUM_CH-1:0] tick
`ifdef FABOSC_TICK_CNT_EN
  ,
  output logic [NUM_CH*TICK_CNT_W-1:0] tick_cnt
`endif
);

  upd_state_t        state_q;
  logic [CH_W-1:0]   shadow_ch_q;
  logic [DIV_W-1:0]  shadow_div_q;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] target;
  logic [NUM_CH-1:0] load;
  logic              accept;
  logic              in_range;
  logic              pend_done;

  assign div_ready = (state_q == UPD_IDLE) && !reset;
  assign accept    = div_valid && div_ready;
  assign in_range  = ({1'b0, div_ch} < (CH_W + 1)'(NUM_CH));

  // A pending update lands when its channel reaches a safe point: wrap, disabled, or SYNC.
  assign pend_done = (state_q == UPD_PEND) && (sync || (|(target & (wrap | ~ch_en))));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= UPD_IDLE;
      shadow_ch_q  <= '0;
      shadow_div_q <= '0;
    end else begin
      unique case (state_q)
        UPD_IDLE: begin
          if (accept && in_range) begin
            shadow_ch_q  <= div_ch;
            shadow_div_q <= div_value;
            state_q      <= UPD_PEND;
          end
        end
        UPD_PEND: begin
          if (pend_done) begin
            state_q <= UPD_IDLE;
          end
        end
        default: state_q <= UPD_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    assign target[i] = (shadow_ch_q == CH_W'(i));
    assign load[i]   = pend_done && target[i];

    fabosc_clken_ch #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en       (ch_en[i]),
      .sync     (sync),
      .load     (load[i]),
      .load_div (shadow_div_q),
      .wrap     (wrap[i]),
      .tick     (tick[i])
`ifdef FABOSC_TICK_CNT_EN
      ,
      .tick_cnt (tick_cnt[i*TICK_CNT_W +: TICK_CNT_W])
`endif
    );
  end

endmodule
